// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the register file: buffers load and ALU results in order and drains
// one per cycle onto the register file write port, with a combinational forwarding lookup.
module regfile_writeback_queue #(
  parameter int DEPTH        = 4,
  parameter int dataWidth    = 64,
  parameter int addressWidth = 5,
  parameter int ZERO_REG     = 31
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic [addressWidth-1:0]   mem_rd,
  input  logic [dataWidth-1:0]      mem_data,
  output logic                      mem_ready,
  input  logic                      alu_valid,
  input  logic [addressWidth-1:0]   alu_rd,
  input  logic [dataWidth-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      wb_stall,
  output logic                      reg_write,
  output logic [addressWidth-1:0]   write_register,
  output logic [dataWidth-1:0]      write_data,
  input  logic [addressWidth-1:0]   fwd_reg,
  output logic                      fwd_hit,
  output logic [dataWidth-1:0]      fwd_data,
  output logic [$clog2(DEPTH):0]    pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [addressWidth-1:0] ZR = addressWidth'(ZERO_REG);

  // Handshake: a producer offers with valid and holds its payload; the transfer happens at the
  // rising edge where valid & ready are both high. Ready depends only on the occupancy at the
  // start of the cycle (and mem_valid for the ALU port), never on wb_stall or a same-cycle pop.

  logic [addressWidth-1:0] rd_q   [DEPTH];
  logic [addressWidth-1:0] rd_d   [DEPTH];
  logic [dataWidth-1:0]    data_q [DEPTH];
  logic [dataWidth-1:0]    data_d [DEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, wr_ptr, idx;
  logic [CW-1:0]           count_q, count_d, free;
  logic                    reg_write_q, reg_write_d;
  logic [addressWidth-1:0] write_register_q, write_register_d;
  logic [dataWidth-1:0]    write_data_q, write_data_d;
  logic                    mem_push, alu_push, pop;

  assign free      = CW'(DEPTH) - count_q;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid);

  always_comb begin
    rd_d             = rd_q;
    data_d           = data_q;
    head_d           = head_q;
    reg_write_d      = reg_write_q;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    pop              = 1'b0;
    // Writes to the zero register complete the handshake but never occupy a slot.
    mem_push = mem_valid & mem_ready & (mem_rd != ZR);
    alu_push = alu_valid & alu_ready & (alu_rd != ZR);
    wr_ptr   = tail_q;
    if (mem_push) begin
      rd_d[wr_ptr]   = mem_rd;
      data_d[wr_ptr] = mem_data;
      wr_ptr         = wr_ptr + PW'(1);
    end
    if (alu_push) begin
      rd_d[wr_ptr]   = alu_rd;
      data_d[wr_ptr] = alu_data;
      wr_ptr         = wr_ptr + PW'(1);
    end
    tail_d = wr_ptr;
    if (~wb_stall | ~reg_write_q) begin
      if (count_q != '0) begin
        pop              = 1'b1;
        reg_write_d      = 1'b1;
        write_register_d = rd_q[head_q];
        write_data_d     = data_q[head_q];
        head_d           = head_q + PW'(1);
      end else begin
        reg_write_d = 1'b0;
      end
    end
    count_d = count_q - CW'(pop) + CW'(mem_push) + CW'(alu_push);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      rd_q             <= rd_d;
      data_q           <= data_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  // Output stage is oldest, then FIFO from head to tail; later matches overwrite earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    if (fwd_reg != ZR) begin
      if (reg_write_q && (write_register_q == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (rd_q[idx] == fwd_reg)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
      end
    end
  end

  assign reg_write      = reg_write_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign pending        = count_q + CW'(reg_write_q);
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: timing, ordering, stall, zero-register,
// back-pressure and asynchronous reset, with a write-order scoreboard.
module tb_regfile_writeback_queue;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int W  = AW + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mem_valid = 1'b0, alu_valid = 1'b0, wb_stall = 1'b0;
  logic [AW-1:0] mem_rd = '0, alu_rd = '0, fwd_reg = '0;
  logic [DW-1:0] mem_data = '0, alu_data = '0;
  logic          mem_ready, alu_ready, reg_write, fwd_hit;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data, fwd_data;
  logic [2:0]    pending;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  regfile_writeback_queue dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_stall(wb_stall), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every accepted write (strobe high, not stalled) must match the next expected one.
  always @(negedge clock) begin
    if (!reset && reg_write && !wb_stall) begin
      if (exp_q.size() == 0) chk("unexpected_write", {write_register, write_data}, '0);
      else chk("wb_order", {write_register, write_data}, exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_pending", pending, 3'd0);
    reset = 1'b0;
    #1;
    chk("rst_write_register", write_register, '0);
    chk("rst_write_data", write_data, '0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);

    // 1: single load, latency and one-cycle strobe
    exp_q.push_back({5'd5, 64'hAA});
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 64'hAA;
    tick();
    mem_valid = 1'b0; fwd_reg = 5'd5;
    #1;
    chk("t1_idle", reg_write, 1'b0);
    chk("t1_pending", pending, 3'd1);
    chk("t1_fwd_hit", fwd_hit, 1'b1);
    chk("t1_fwd_data", fwd_data, 64'hAA);
    tick();
    chk("t1_strobe", reg_write, 1'b1);
    chk("t1_reg", write_register, 5'd5);
    chk("t1_data", write_data, 64'hAA);
    tick();
    chk("t1_strobe_off", reg_write, 1'b0);
    chk("t1_pending_end", pending, 3'd0);

    // 2: simultaneous mem/alu to same rd, alu is younger
    exp_q.push_back({5'd3, 64'd1});
    exp_q.push_back({5'd3, 64'd2});
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'd1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'd2;
    #1;
    chk("t2_mem_ready", mem_ready, 1'b1);
    chk("t2_alu_ready", alu_ready, 1'b1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0; fwd_reg = 5'd3;
    #1;
    chk("t2_fwd_both_fifo", fwd_data, 64'd2);
    tick();
    chk("t2_first_data", write_data, 64'd1);
    chk("t2_fwd_out_plus_fifo", fwd_data, 64'd2);
    tick();
    chk("t2_second_strobe", reg_write, 1'b1);
    chk("t2_second_data", write_data, 64'd2);
    tick();
    chk("t2_done", reg_write, 1'b0);

    // 3: stall, fill all five slots, then drain back to back
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({AW'(10 + i), DW'(64'h100 + i)});
      alu_valid = 1'b1; alu_rd = AW'(10 + i); alu_data = DW'(64'h100 + i);
      #1;
      chk("t3_alu_ready_fill", alu_ready, 1'b1);
      tick();
    end
    alu_rd = 5'd20; alu_data = 64'hDEAD;
    #1;
    chk("t3_alu_ready_full", alu_ready, 1'b0);
    chk("t3_mem_ready_full", mem_ready, 1'b0);
    chk("t3_pending_full", pending, 3'd5);
    tick();
    alu_valid = 1'b0;
    chk("t3_no_accept_full", pending, 3'd5);
    chk("t3_hold_reg", write_register, 5'd10);
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_drain_strobe", reg_write, 1'b1);
      chk("t3_drain_reg", write_register, AW'(10 + i));
      tick();
    end
    chk("t3_drain_end", reg_write, 1'b0);

    // 4: zero-register write is consumed and dropped
    alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hFF; fwd_reg = 5'd31;
    #1;
    chk("t4_alu_ready", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk("t4_pending", pending, 3'd0);
    chk("t4_fwd_hit", fwd_hit, 1'b0);
    chk("t4_fwd_data", fwd_data, 64'd0);
    tick();
    chk("t4_no_write", reg_write, 1'b0);

    // 5: one free slot with both offering -> only mem accepted
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({AW'(1 + i), DW'(64'h51 + i)});
      alu_valid = 1'b1; alu_rd = AW'(1 + i); alu_data = DW'(64'h51 + i);
      tick();
    end
    alu_rd = 5'd7; alu_data = 64'h77;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'h66;
    #1;
    chk("t5_pending_one_free", pending, 3'd4);
    chk("t5_mem_ready", mem_ready, 1'b1);
    chk("t5_alu_ready", alu_ready, 1'b0);
    exp_q.push_back({5'd6, 64'h66});
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0; fwd_reg = 5'd7;
    #1;
    chk("t5_pending", pending, 3'd5);
    chk("t5_alu_not_taken", fwd_hit, 1'b0);
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_drained", pending, 3'd0);

    // 6: asynchronous reset with writes pending
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(8 + i); alu_data = DW'(64'h80 + i);
      tick();
    end
    alu_valid = 1'b0;
    chk("t6_pending3", pending, 3'd3);
    chk("t6_strobe_before", reg_write, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_async_strobe", reg_write, 1'b0);
    chk("t6_async_pending", pending, 3'd0);
    tick();
    reset = 1'b0; wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_write", reg_write, 1'b0);
    end
    chk("t6_reg_cleared", write_register, '0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
